// File: rtl/round_pipe_if.sv
// round_pipe_if: input and output channels of the rounding pipeline.
interface round_pipe_if #(
  parameter int unsigned EW = 8,
  parameter int unsigned FW = 29
);
  logic          in_valid;
  logic          in_ready;
  logic          in_sign;
  logic          in_normalized;
  logic [1:0]    in_mode;
  logic [EW-1:0] in_exp;
  logic [FW-1:0] in_fract;

  logic          out_valid;
  logic          out_ready;
  logic          out_sign;
  logic [EW-1:0] out_exp;
  logic [FW-1:0] out_fract;
  logic          out_inexact;
  logic          out_overflow;

  // Producer of operands / consumer of results.
  modport master (
    output in_valid, in_sign, in_normalized, in_mode, in_exp, in_fract, out_ready,
    input  in_ready, out_valid, out_sign, out_exp, out_fract, out_inexact, out_overflow
  );

  // The rounding unit itself.
  modport slave (
    input  in_valid, in_sign, in_normalized, in_mode, in_exp, in_fract, out_ready,
    output in_ready, out_valid, out_sign, out_exp, out_fract, out_inexact, out_overflow
  );
endinterface

// File: rtl/round_pipe.sv
// round_pipe: two-stage rounding unit. Stage 1 decides the increment and adds it,
// stage 2 renormalises on carry-out, saturates on overflow and drives the result.
module round_pipe #(
  parameter int unsigned EW = 8,
  parameter int unsigned FW = 29,
  parameter int unsigned GB = 3
) (
  input  logic        clk,
  input  logic        rst,
  round_pipe_if.slave bus
);
  localparam int unsigned   KW      = FW - GB;
  localparam logic [GB-1:0] HALF    = {1'b1, {(GB-1){1'b0}}};
  localparam logic [EW:0]   EXP_MAX = {1'b0, {EW{1'b1}}};

  // Stage 1 state
  logic          s1_valid;
  logic          s1_sign;
  logic          s1_bypass;
  logic          s1_inexact;
  logic [EW-1:0] s1_exp;
  logic [FW-1:0] s1_fract;

  // Stage 2 (output) state
  logic          s2_valid;
  logic          s2_sign;
  logic          s2_inexact;
  logic          s2_overflow;
  logic [EW-1:0] s2_exp;
  logic [FW-1:0] s2_fract;

  logic s1_en;
  logic s2_en;

  logic [KW-1:0] kept_c;
  logic [GB-1:0] rem_c;
  logic          inc_c;
  logic [KW-1:0] sum_c;

  logic          carry_c;
  logic [EW:0]   exp_next_c;
  logic [EW-1:0] r_exp_c;
  logic [FW-1:0] r_fract_c;
  logic          r_inexact_c;
  logic          r_overflow_c;

  // A stage may load when it is empty or its contents move on this edge.
  assign s2_en        = ~s2_valid | bus.out_ready;
  assign s1_en        = ~s1_valid | s2_en;
  assign bus.in_ready = s1_en;

  // Increment decision for the selected rounding mode, then the rounded sum.
  always_comb begin
    kept_c = bus.in_fract[FW-1:GB];
    rem_c  = bus.in_fract[GB-1:0];
    inc_c  = 1'b0;
    case (bus.in_mode)
      2'b00:   inc_c = (rem_c > HALF) || ((rem_c == HALF) && kept_c[0]);
      2'b01:   inc_c = 1'b0;
      2'b10:   inc_c = (rem_c != '0) && !bus.in_sign;
      2'b11:   inc_c = (rem_c != '0) && bus.in_sign;
      default: inc_c = 1'b0;
    endcase
    sum_c = kept_c + KW'(inc_c);
  end

  // Stage 1 register; bypassed operands keep their raw fraction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid   <= 1'b0;
      s1_sign    <= 1'b0;
      s1_bypass  <= 1'b0;
      s1_inexact <= 1'b0;
      s1_exp     <= '0;
      s1_fract   <= '0;
    end else if (s1_en) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_sign    <= bus.in_sign;
        s1_bypass  <= ~bus.in_normalized;
        s1_inexact <= (rem_c != '0);
        s1_exp     <= bus.in_exp;
        s1_fract   <= bus.in_normalized ? {sum_c, {GB{1'b0}}} : bus.in_fract;
      end
    end
  end

  // Carry renormalisation and exponent saturation; exponent grows one bit so it cannot wrap.
  always_comb begin
    carry_c      = s1_fract[FW-1] & ~s1_bypass;
    exp_next_c   = {1'b0, s1_exp} + (EW+1)'(carry_c);
    r_exp_c      = s1_exp;
    r_fract_c    = s1_fract;
    r_inexact_c  = 1'b0;
    r_overflow_c = 1'b0;
    if (!s1_bypass) begin
      r_inexact_c = s1_inexact;
      r_exp_c     = exp_next_c[EW-1:0];
      if (carry_c) begin
        r_fract_c = {1'b0, s1_fract[FW-1:GB+1], {GB{1'b0}}};
      end
      if (exp_next_c >= EXP_MAX) begin
        r_exp_c      = '1;
        r_fract_c    = '0;
        r_overflow_c = 1'b1;
      end
    end
  end

  // Output register; a bubble clears data and flags so nothing is shown without valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid    <= 1'b0;
      s2_sign     <= 1'b0;
      s2_inexact  <= 1'b0;
      s2_overflow <= 1'b0;
      s2_exp      <= '0;
      s2_fract    <= '0;
    end else if (s2_en) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_sign     <= s1_sign;
        s2_inexact  <= r_inexact_c;
        s2_overflow <= r_overflow_c;
        s2_exp      <= r_exp_c;
        s2_fract    <= r_fract_c;
      end else begin
        s2_sign     <= 1'b0;
        s2_inexact  <= 1'b0;
        s2_overflow <= 1'b0;
        s2_exp      <= '0;
        s2_fract    <= '0;
      end
    end
  end

  assign bus.out_valid    = s2_valid;
  assign bus.out_sign     = s2_sign;
  assign bus.out_exp      = s2_exp;
  assign bus.out_fract    = s2_fract;
  assign bus.out_inexact  = s2_inexact;
  assign bus.out_overflow = s2_overflow;
endmodule
